inst_queue: RTL

- Parametrised instruction buffer between fetch and decode; next generation of the single-entry fetch/decode valid/ready handoff.
- Accepts up to IN_WIDTH instructions per cycle from fetch and presents up to OUT_WIDTH oldest instructions per cycle to a multi-issue decode.
- Carries fetch-side exception info with each instruction.
- Flushes on redirect, optionally retaining exactly one instruction (the branch delay slot), including the case where the delay slot has not yet arrived.

---
 rtl/inst_queue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/inst_queue.sv
// inst_queue: multi-lane instruction buffer between fetch and decode.
//   Circular store of {pc, inst, exc, exccode}. Up to IN_WIDTH lanes are pushed per
//   cycle and the OUT_WIDTH oldest entries are read combinationally. Flush can
//   optionally retain one instruction (branch delay slot), even one not yet fetched.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_mask           fetch group valid, contiguous lane mask
//   in_pc/in_inst              per-lane PC and instruction word (lane i at [32i+:32])
//   in_exc/in_exccode          per-lane fetch exception flag and 5-bit code
//   in_ready                   room for a full group (or waiting for the delay slot)
//   out_valid                  thermometer of valid head entries
//   out_pc/out_inst/out_exc/out_exccode  head entries' payload
//   pop_count                  entries consumed by decode this cycle
//   flush/flush_keep_one       discard contents, optionally keeping one survivor
//   count                      current occupancy
module inst_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IN_WIDTH  = 2,
  parameter int unsigned OUT_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [IN_WIDTH-1:0]              in_mask,
  input  logic [32*IN_WIDTH-1:0]           in_pc,
  input  logic [32*IN_WIDTH-1:0]           in_inst,
  input  logic [IN_WIDTH-1:0]              in_exc,
  input  logic [5*IN_WIDTH-1:0]            in_exccode,
  output logic                             in_ready,
  output logic [OUT_WIDTH-1:0]             out_valid,
  output logic [32*OUT_WIDTH-1:0]          out_pc,
  output logic [32*OUT_WIDTH-1:0]          out_inst,
  output logic [OUT_WIDTH-1:0]             out_exc,
  output logic [5*OUT_WIDTH-1:0]           out_exccode,
  input  logic [$clog2(OUT_WIDTH+1)-1:0]   pop_count,
  input  logic                             flush,
  input  logic                             flush_keep_one,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic        exc_mem  [DEPTH];
  logic [4:0]  code_mem [DEPTH];

  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic                keep_q, keep_d;
  logic [PW-1:0]       cnt, n_in, pop_ext, surv;
  logic [IN_WIDTH-1:0] wr_en;
  logic [AW-1:0]       wr_idx [IN_WIDTH];

  // Pointers carry a wrap bit, so plain subtraction yields occupancy 0..DEPTH.
  assign cnt      = tail_q - head_q;
  assign count    = cnt;
  assign pop_ext  = PW'(pop_count);
  assign surv     = head_q + pop_ext;
  assign in_ready = keep_q || (cnt <= PW'(DEPTH - IN_WIDTH));

  always_comb begin
    n_in = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      n_in = n_in + PW'(in_mask[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      wr_idx[i] = tail_q[AW-1:0] + AW'(i);
    end
  end

  // Next-state for pointers, delay-slot flag and write enables.
  always_comb begin
    head_d = head_q + pop_ext;
    tail_d = tail_q;
    keep_d = keep_q;
    wr_en  = '0;
    if (flush) begin
      keep_d = 1'b0;
      if (!flush_keep_one) begin
        head_d = tail_q;
      end else if (cnt > pop_ext) begin
        // Oldest entry not consumed this cycle becomes the sole survivor.
        head_d = surv;
        tail_d = surv + PW'(1);
      end else if (in_valid && in_mask[0]) begin
        // Delay slot arrives in the same cycle; taken regardless of in_ready.
        wr_en[0] = 1'b1;
        head_d   = tail_q;
        tail_d   = tail_q + PW'(1);
      end else begin
        head_d = tail_q;
        keep_d = 1'b1;
      end
    end else if (keep_q) begin
      if (in_valid && in_mask[0]) begin
        wr_en[0] = 1'b1;
        tail_d   = tail_q + PW'(1);
        keep_d   = 1'b0;
      end
    end else if (in_valid && in_ready) begin
      wr_en  = in_mask;
      tail_d = tail_q + n_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      keep_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      keep_q <= keep_d;
    end
  end

  // Entry storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (wr_en[i]) begin
        pc_mem[wr_idx[i]]   <= in_pc[32*i +: 32];
        inst_mem[wr_idx[i]] <= in_inst[32*i +: 32];
        exc_mem[wr_idx[i]]  <= in_exc[i];
        code_mem[wr_idx[i]] <= in_exccode[5*i +: 5];
      end
    end
  end

  for (genvar o = 0; o < OUT_WIDTH; o++) begin : g_out
    logic [AW-1:0] rd_idx;
    assign rd_idx             = head_q[AW-1:0] + AW'(o);
    assign out_valid[o]       = cnt > PW'(o);
    assign out_pc[32*o +: 32]   = pc_mem[rd_idx];
    assign out_inst[32*o +: 32] = inst_mem[rd_idx];
    assign out_exc[o]         = exc_mem[rd_idx];
    assign out_exccode[5*o +: 5] = code_mem[rd_idx];
  end

endmodule
